// File: rtl/sync_fifo_pkg.sv
// Shared widths, helpers and parameter legality checks for sync_fifo_flags.
// Used by both the registered-read and SYNC_FIFO_FWFT_EN builds.
package sync_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int af, input int ae);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0)
            && (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_ram.sv
// Simple dual-port storage: synchronous write, read port combinational
// under SYNC_FIFO_FWFT_EN, otherwise a registered read with enable.
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_ok;
    assign unused_ok = ^{rst, re_i};
    assign rdata_o   = mem_q[raddr_i];
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [clog2(DEPTH):0] level,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_THRESH);

    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_flags: illegal WIDTH/DEPTH/threshold parameters");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;

    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (wr_en && !wr_acc);
        unf_d    = unf_q | (rd_en && !rd_acc);
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc && !rst),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_valid = !empty;
`else
    logic rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) rd_valid_q <= 1'b0;
        else     rd_valid_q <= rd_acc;
    end

    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed plus random bench for sync_fifo_flags against a queue model.
// Works for both the registered and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid, full, empty, almost_full, almost_empty;
    logic [LW-1:0]    level;
    logic             overflow, underflow;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] last_rd;
    bit               m_ovf, m_unf, m_vld;

    sync_fifo_flags #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level", 32'(level), n);
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(n != 0));
        if (n != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`else
        chk("rd_valid", 32'(rd_valid), 32'(m_vld));
        chk("rd_data", 32'(rd_data), 32'(last_rd));
`endif
    endtask

    task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d);
        bit ra, wa;
        @(negedge clk);
        rst     = 1'b0;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        ra = r && (q.size() > 0);
        wa = w && ((q.size() < DEPTH) || ra);
        @(posedge clk);
        if (ra) last_rd = q.pop_front();
        if (wa) q.push_back(d);
        if (w && !wa) m_ovf = 1'b1;
        if (r && !ra) m_unf = 1'b1;
        m_vld = ra;
        #1 check_all();
    endtask

    task automatic do_reset(input bit w, input bit r);
        @(negedge clk);
        rst     = 1'b1;
        wr_en   = w;
        rd_en   = r;
        wr_data = WIDTH'($urandom);
        @(posedge clk);
        q.delete();
        last_rd = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_vld   = 1'b0;
        #1 check_all();
    endtask

    initial begin
        int pw, pr;
        last_rd = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_vld = 1'b0;

        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);

        // fill, then one write too many
        for (int i = 1; i <= DEPTH + 1; i++) step(1'b1, 1'b0, WIDTH'(i));

        // drain, then one read too many
        for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, '0);

        // full with simultaneous write/read
        do_reset(1'b1, 1'b1);
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i));
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

        // empty with both requests: write only
        step(1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b1, '0);

        // streaming with a reset pulse in the middle
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < 40; i++) begin
            if (i == 20) do_reset(1'b1, 1'b1);
            else step(1'b1, 1'b1, WIDTH'($urandom));
        end

        // random phases with varying bias
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 199) == 0)
                    do_reset(1'($urandom), 1'($urandom));
                else
                    step($urandom_range(0, 99) < pw,
                         $urandom_range(0, 99) < pr,
                         WIDTH'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
